// File: rtl/fp_matmul_operand_loader.sv
// fp_matmul_operand_loader
// Serial-to-parallel operand buffer for the fixed-point matrix multiplier.
// Q8.8 elements arrive one per handshake: all of A (row-major), then all of B.
// Both matrices are then held stable with out_valid until downstream accepts them.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   clear               synchronous abort of the current load (highest priority)
//   in_valid/in_ready   element stream handshake, in_data = element
//   out_valid/out_ready operand-pair handshake
//   out_1               matrix A, element (r,c) at slice r*COL_1+c, slice 0 at LSBs
//   out_2               matrix B, element (r,c) at slice r*COL_2+c, slice 0 at LSBs
//
// Build option: define FP_LOADER_TRANSPOSE_B_EN to accept B column-major
// (e.g. K^T); accepted B element k then lands in slice (k % ROW_2)*COL_2 + k/ROW_2.
module fp_matmul_operand_loader #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ROW_1      = 4,
  parameter int unsigned COL_1      = 4,
  parameter int unsigned ROW_2      = 4,
  parameter int unsigned COL_2      = 2
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                clear,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [DATA_WIDTH-1:0]               in_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [DATA_WIDTH*ROW_1*COL_1-1:0]   out_1,
  output logic [DATA_WIDTH*ROW_2*COL_2-1:0]   out_2
);

  localparam int unsigned N_A   = ROW_1 * COL_1;
  localparam int unsigned N_B   = ROW_2 * COL_2;
  localparam int unsigned N_MAX = (N_A > N_B) ? N_A : N_B;
  localparam int unsigned CNT_W = (N_MAX > 1) ? $clog2(N_MAX) : 1;
  localparam int unsigned A_IW  = (N_A > 1) ? $clog2(N_A) : 1;
  localparam int unsigned B_IW  = (N_B > 1) ? $clog2(N_B) : 1;

  localparam logic [1:0] LOAD_A = 2'd0;
  localparam logic [1:0] LOAD_B = 2'd1;
  localparam logic [1:0] HOLD   = 2'd2;

  logic [1:0]                          r_state;
  logic [1:0]                          w_state_nxt;
  logic [CNT_W-1:0]                    r_cnt;
  logic [CNT_W-1:0]                    w_cnt_nxt;
  logic                                r_out_valid;
  logic [N_A-1:0][DATA_WIDTH-1:0]      r_mat_a;
  logic [N_B-1:0][DATA_WIDTH-1:0]      r_mat_b;
  logic                                w_acc;
  logic                                w_wr_a;
  logic                                w_wr_b;
  logic [A_IW-1:0]                     w_idx_a;
  logic [B_IW-1:0]                     w_idx_b;

  // in_ready depends on state only, so there is no path from out_ready/in_valid
  assign in_ready  = (r_state != HOLD);
  assign out_valid = r_out_valid;
  assign out_1     = r_mat_a;
  assign out_2     = r_mat_b;
  assign w_acc     = in_valid && in_ready;
  assign w_idx_a   = A_IW'(r_cnt);

  // B destination slice: row-major by default, column-major when transposed
`ifdef FP_LOADER_TRANSPOSE_B_EN
  logic [31:0] w_k;
  assign w_k     = 32'(r_cnt);
  assign w_idx_b = B_IW'((w_k % ROW_2) * COL_2 + (w_k / ROW_2));
`else
  assign w_idx_b = B_IW'(r_cnt);
`endif

  // State and element counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= LOAD_A;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_out_valid <= (w_state_nxt == HOLD);
    end
  end

  // Next-state, counter and write-enable decode; clear overrides every handshake
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_wr_a      = 1'b0;
    w_wr_b      = 1'b0;
    if (clear) begin
      w_state_nxt = LOAD_A;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        LOAD_A: begin
          if (w_acc) begin
            w_wr_a = 1'b1;
            if (r_cnt == CNT_W'(N_A - 1)) begin
              w_state_nxt = LOAD_B;
              w_cnt_nxt   = '0;
            end else begin
              w_cnt_nxt = r_cnt + CNT_W'(1);
            end
          end
        end
        LOAD_B: begin
          if (w_acc) begin
            w_wr_b = 1'b1;
            if (r_cnt == CNT_W'(N_B - 1)) begin
              w_state_nxt = HOLD;
              w_cnt_nxt   = '0;
            end else begin
              w_cnt_nxt = r_cnt + CNT_W'(1);
            end
          end
        end
        HOLD: begin
          if (r_out_valid && out_ready) begin
            w_state_nxt = LOAD_A;
            w_cnt_nxt   = '0;
          end
        end
        default: begin
          w_state_nxt = LOAD_A;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Operand buffers; slices are overwritten in place by each new batch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mat_a <= '0;
      r_mat_b <= '0;
    end else begin
      if (w_wr_a) r_mat_a[w_idx_a] <= in_data;
      if (w_wr_b) r_mat_b[w_idx_b] <= in_data;
    end
  end

endmodule

// File: tb/tb_fp_matmul_operand_loader.sv
// Scoreboard bench for fp_matmul_operand_loader: stimulus pushes the expected
// operand pair, a negedge monitor pops and compares whenever out_valid is up.
module tb_fp_matmul_operand_loader;

  localparam int unsigned DW  = 16;
  localparam int unsigned NA  = 16;
  localparam int unsigned NB  = 8;
  localparam int unsigned R2  = 4;
  localparam int unsigned C2  = 2;
  localparam int unsigned W1  = DW * NA;
  localparam int unsigned W2  = DW * NB;

  logic          clk;
  logic          rst_n;
  logic          clear;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W1-1:0] out_1;
  logic [W2-1:0] out_2;

  int checks;
  int failures;

  typedef struct packed {
    logic [W1-1:0] m1;
    logic [W2-1:0] m2;
  } pair_t;

  pair_t sb_q[$];
  pair_t cur_exp;
  bit    seen;

  fp_matmul_operand_loader dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_1    (out_1),
    .out_2    (out_2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W1-1:0] act, input logic [W1-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected slice of B element k as it arrives on the stream
  function automatic int unsigned b_slice(input int unsigned k);
`ifdef FP_LOADER_TRANSPOSE_B_EN
    return (k % R2) * C2 + (k / R2);
`else
    return k;
`endif
  endfunction

  task automatic send(input logic [DW-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Full batch: A elements a0+k*ainc, B elements b0+k; optional one-cycle bubbles
  task automatic load_batch(input logic [DW-1:0] a0, input logic [DW-1:0] ainc,
                            input logic [DW-1:0] b0, input bit bubble);
    pair_t e;
    logic [DW-1:0] v;
    e = '0;
    for (int k = 0; k < NA; k++) begin
      v = a0 + DW'(k) * ainc;
      e.m1[k*DW +: DW] = v;
    end
    for (int k = 0; k < NB; k++) begin
      v = b0 + DW'(k);
      e.m2[b_slice(k)*DW +: DW] = v;
    end
    sb_q.push_back(e);
    for (int k = 0; k < NA + NB; k++) begin
      if (k == NA + NB - 1) chk("valid_before_last", W1'(out_valid), W1'(0));
      if (k < NA) send(a0 + DW'(k) * ainc);
      else        send(b0 + DW'(k - NA));
      if (bubble && k != NA + NB - 1) begin
        @(posedge clk); #1;
      end
    end
    chk("valid_latency", W1'(out_valid), W1'(1));
  endtask

  task automatic hold_release(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("valid_after_release", W1'(out_valid), W1'(0));
    chk("ready_after_release", W1'(in_ready), W1'(1));
  endtask

  // Monitor: compare the full pair on every held cycle against the popped expectation
  always @(negedge clk) begin
    if (!rst_n) begin
      seen = 1'b0;
    end else if (out_valid) begin
      if (!seen) begin
        checks++;
        if (sb_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_out: got out_valid=1 expected no pending pair");
          cur_exp = {out_1, out_2};
        end else begin
          cur_exp = sb_q.pop_front();
        end
        seen = 1'b1;
      end
      chk("out_1", out_1, cur_exp.m1);
      chk("out_2", W1'(out_2), W1'(cur_exp.m2));
      chk("ready_in_hold", W1'(in_ready), W1'(0));
    end else begin
      seen = 1'b0;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; failures = 0; seen = 1'b0; cur_exp = '0;
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #12;
    chk("rst_valid", W1'(out_valid), W1'(0));
    chk("rst_out_1", out_1, W1'(0));
    chk("rst_out_2", W1'(out_2), W1'(0));
    chk("rst_ready", W1'(in_ready), W1'(1));
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_valid", W1'(out_valid), W1'(0));
    chk("post_rst_ready", W1'(in_ready), W1'(1));

    // Continuous stream, held 5 cycles
    load_batch(16'h0001, 16'h0001, 16'h0101, 1'b0);
    hold_release(5);
    // Same data with bubbles
    load_batch(16'h0001, 16'h0001, 16'h0101, 1'b1);
    hold_release(2);
    // A = 0x0100 everywhere overwrites out_1
    load_batch(16'h0100, 16'h0000, 16'h0301, 1'b0);
    hold_release(1);

    // Abort after 10 A elements; clear with in_valid=1 must not write
    for (int k = 0; k < 10; k++) send(16'h0A00 + DW'(k));
    in_valid = 1'b1; in_data = 16'hDEAD; clear = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; clear = 1'b0;
    chk("clear_valid", W1'(out_valid), W1'(0));
    chk("clear_ready", W1'(in_ready), W1'(1));
    load_batch(16'h0400, 16'h0001, 16'h0501, 1'b0);
    // clear while holding drops out_valid
    @(posedge clk); #1;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    chk("clear_hold_valid", W1'(out_valid), W1'(0));
    chk("clear_hold_ready", W1'(in_ready), W1'(1));

    // Asynchronous reset during LOAD_B
    for (int k = 0; k < NA + 3; k++) send(16'h0700 + DW'(k));
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", W1'(out_valid), W1'(0));
    chk("mid_rst_out_1", out_1, W1'(0));
    chk("mid_rst_out_2", W1'(out_2), W1'(0));
    chk("mid_rst_ready", W1'(in_ready), W1'(1));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    load_batch(16'h0601, 16'h0001, 16'h0801, 1'b0);
    hold_release(3);

    chk("sb_empty", W1'(sb_q.size()), W1'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
